// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Multi-cycle control FSM for the 2-bit op / 6-bit funct ISA. One shared ALU
// and one unified instruction/data memory port are sequenced through FETCH,
// DECODE, EXECUTE, MEMORY and WRITEBACK cycles. Memory accesses use a
// req/ready handshake guarded by a wait-cycle timeout.
//
// Parameters
//   TIMEOUT       maximum wait cycles for mem_ready in a memory state
//                 (0 disables the timeout)
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   op, funct     instruction fields from the IR output
//   mem_ready     memory accepts / returns data this cycle
//   mem_req       memory access request
//   adr_src       memory address select (0 = PC, 1 = ALUOut)
//   memW          memory write, qualified by mem_req
//   ir_write      load IR from memory read data
//   pc_write      load PC with the ALU result (PC+4)
//   alu_srcA      ALU A select (0 = PC, 1 = register A)
//   alu_srcB      ALU B select (00 = reg B, 01 = ext. immediate, 10 = 4)
//   alu_op        000 add, 001 sub, 100 and, 101 orr
//   shift_dir     0 = left, 1 = right
//   aluorshft     result select (1 = shifter, 0 = ALU)
//   reg_A2src     register read port 2 address select
//   immsrc        immediate format select
//   regW          register file write
//   flagW         flag register write
//   result_src    writeback select (0 = ALUOut, 1 = memory data register)
//   illegal_instr one-cycle pulse on an undecodable instruction
//   bus_error     one-cycle pulse on a memory timeout
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       memW,
  output logic       ir_write,
  output logic       pc_write,
  output logic       alu_srcA,
  output logic [1:0] alu_srcB,
  output logic [2:0] alu_op,
  output logic       shift_dir,
  output logic       aluorshft,
  output logic       reg_A2src,
  output logic       immsrc,
  output logic       regW,
  output logic       flagW,
  output logic       result_src,
  output logic       illegal_instr,
  output logic       bus_error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_ALU_WB,
    S_MEM_ADR,
    S_MEM_RD,
    S_MEM_WR,
    S_MEM_WB
  } state_e;

  localparam logic [1:0] OP_R  = 2'b00;
  localparam logic [1:0] OP_M  = 2'b01;

  localparam logic [5:0] F_ADD = 6'b001000;
  localparam logic [5:0] F_SUB = 6'b000100;
  localparam logic [5:0] F_AND = 6'b000000;
  localparam logic [5:0] F_ORR = 6'b011000;
  localparam logic [5:0] F_LSR = 6'b111110;
  localparam logic [5:0] F_LSL = 6'b111100;
  localparam logic [5:0] F_CMP = 6'b010101;
  localparam logic [5:0] F_STR = 6'b011000;
  localparam logic [5:0] F_LDR = 6'b011001;

  // A zero-width counter is not legal, so TIMEOUT=0 keeps a 1-bit counter
  // that is simply held at zero.
  localparam int unsigned      CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q;
  logic [5:0]       funct_q;
  logic             latch_en;
  logic             tmo;

  function automatic logic is_rtype(input logic [1:0] o, input logic [5:0] f);
    return (o == OP_R) &&
           ((f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_ORR) ||
            (f == F_LSR) || (f == F_LSL) || (f == F_CMP));
  endfunction

  function automatic logic is_mem(input logic [1:0] o, input logic [5:0] f);
    return (o == OP_M) && ((f == F_STR) || (f == F_LDR));
  endfunction

  // This waiting cycle is the TIMEOUT-th one: cnt_q counts the waits already
  // spent, so the current cycle is wait number cnt_q+1.
  assign tmo = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Instruction copy used by every state after DECODE; the IR output may
  // change once PC/IR move on, so it must not be read directly later.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      op_q    <= op;
      funct_q <= funct;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    latch_en      = 1'b0;
    mem_req       = 1'b0;
    adr_src       = 1'b0;
    memW          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    alu_srcA      = 1'b0;
    alu_srcB      = 2'b00;
    alu_op        = 3'b000;
    shift_dir     = 1'b0;
    aluorshft     = 1'b0;
    reg_A2src     = 1'b0;
    immsrc        = 1'b0;
    regW          = 1'b0;
    flagW         = 1'b0;
    result_src    = 1'b0;
    illegal_instr = 1'b0;
    bus_error     = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req  = 1'b1;
        alu_srcB = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (tmo) begin
          bus_error = 1'b1;
          state_d   = S_FETCH;
        end else begin
          cnt_d = (TIMEOUT > 0) ? cnt_q + 1'b1 : '0;
        end
      end

      S_DECODE: begin
        latch_en = 1'b1;
        if (is_rtype(op, funct)) begin
          state_d = S_EXEC_R;
        end else if (is_mem(op, funct)) begin
          state_d = S_MEM_ADR;
        end else begin
          illegal_instr = 1'b1;
          state_d       = S_FETCH;
        end
      end

      S_EXEC_R: begin
        alu_srcA = 1'b1;
        unique case (funct_q)
          F_SUB, F_CMP: alu_op = 3'b001;
          F_AND:        alu_op = 3'b100;
          F_ORR:        alu_op = 3'b101;
          F_LSR: begin
            aluorshft = 1'b1;
            shift_dir = 1'b1;
          end
          F_LSL:        aluorshft = 1'b1;
          default:      alu_op = 3'b000;
        endcase
        if (funct_q == F_CMP) begin
          flagW   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_ALU_WB;
        end
      end

      S_ALU_WB: begin
        regW    = 1'b1;
        state_d = S_FETCH;
      end

      S_MEM_ADR: begin
        alu_srcA  = 1'b1;
        alu_srcB  = 2'b01;
        immsrc    = 1'b1;
        reg_A2src = 1'b1;
        state_d   = ((op_q == OP_M) && (funct_q == F_LDR)) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (tmo) begin
          bus_error = 1'b1;
          state_d   = S_FETCH;
        end else begin
          cnt_d = (TIMEOUT > 0) ? cnt_q + 1'b1 : '0;
        end
      end

      S_MEM_WR: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        memW    = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (tmo) begin
          bus_error = 1'b1;
          state_d   = S_FETCH;
        end else begin
          cnt_d = (TIMEOUT > 0) ? cnt_q + 1'b1 : '0;
        end
      end

      S_MEM_WB: begin
        regW       = 1'b1;
        result_src = 1'b1;
        state_d    = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk;
  logic       reset_n;
  logic [1:0] op;
  logic [5:0] funct;
  logic       mem_ready;
  logic       mem_req, adr_src, memW, ir_write, pc_write, alu_srcA;
  logic [1:0] alu_srcB;
  logic [2:0] alu_op;
  logic       shift_dir, aluorshft, reg_A2src, immsrc, regW, flagW;
  logic       result_src, illegal_instr, bus_error;
  logic [19:0] act;

  int n_chk  = 0;
  int n_fail = 0;

  multicycle_controller #(.TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .adr_src(adr_src), .memW(memW), .ir_write(ir_write),
    .pc_write(pc_write), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_op(alu_op),
    .shift_dir(shift_dir), .aluorshft(aluorshft), .reg_A2src(reg_A2src),
    .immsrc(immsrc), .regW(regW), .flagW(flagW), .result_src(result_src),
    .illegal_instr(illegal_instr), .bus_error(bus_error)
  );

  assign act = {mem_req, adr_src, memW, ir_write, pc_write, alu_srcA, alu_srcB,
                alu_op, shift_dir, aluorshft, reg_A2src, immsrc, regW, flagW,
                result_src, illegal_instr, bus_error};

  // Output bit masks, in the packing order of act.
  localparam logic [19:0] M_MREQ  = 20'h80000;
  localparam logic [19:0] M_ADR   = 20'h40000;
  localparam logic [19:0] M_MW    = 20'h20000;
  localparam logic [19:0] M_IRW   = 20'h10000;
  localparam logic [19:0] M_PCW   = 20'h08000;
  localparam logic [19:0] M_SA    = 20'h04000;
  localparam logic [19:0] SB_4    = 20'h02000;
  localparam logic [19:0] SB_IMM  = 20'h01000;
  localparam logic [19:0] AOP_AND = 20'h00800;
  localparam logic [19:0] AOP_ORR = 20'h00A00;
  localparam logic [19:0] AOP_SUB = 20'h00200;
  localparam logic [19:0] M_SD    = 20'h00100;
  localparam logic [19:0] M_AOS   = 20'h00080;
  localparam logic [19:0] M_A2    = 20'h00040;
  localparam logic [19:0] M_IMM   = 20'h00020;
  localparam logic [19:0] M_RW    = 20'h00010;
  localparam logic [19:0] M_FW    = 20'h00008;
  localparam logic [19:0] M_RS    = 20'h00004;
  localparam logic [19:0] M_ILL   = 20'h00002;
  localparam logic [19:0] M_BE    = 20'h00001;

  localparam logic [19:0] E_IDLE  = 20'h00000;
  localparam logic [19:0] E_DEC   = 20'h00000;
  localparam logic [19:0] E_FW    = M_MREQ | SB_4;
  localparam logic [19:0] E_FOK   = E_FW | M_IRW | M_PCW;
  localparam logic [19:0] E_FTO   = E_FW | M_BE;
  localparam logic [19:0] E_ILL   = M_ILL;
  localparam logic [19:0] E_XADD  = M_SA;
  localparam logic [19:0] E_XSUB  = M_SA | AOP_SUB;
  localparam logic [19:0] E_XCMP  = M_SA | AOP_SUB | M_FW;
  localparam logic [19:0] E_XAND  = M_SA | AOP_AND;
  localparam logic [19:0] E_XORR  = M_SA | AOP_ORR;
  localparam logic [19:0] E_XLSR  = M_SA | M_SD | M_AOS;
  localparam logic [19:0] E_XLSL  = M_SA | M_AOS;
  localparam logic [19:0] E_AWB   = M_RW;
  localparam logic [19:0] E_MADR  = M_SA | SB_IMM | M_A2 | M_IMM;
  localparam logic [19:0] E_MRD   = M_MREQ | M_ADR;
  localparam logic [19:0] E_MRDTO = E_MRD | M_BE;
  localparam logic [19:0] E_MWR   = E_MRD | M_MW;
  localparam logic [19:0] E_MWB   = M_RW | M_RS;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] M = 2'b01;
  localparam logic [5:0] ADD = 6'b001000, SUB = 6'b000100, AND_ = 6'b000000;
  localparam logic [5:0] ORR = 6'b011000, LSR = 6'b111110, LSL = 6'b111100;
  localparam logic [5:0] CMP = 6'b010101, STR = 6'b011000, LDR = 6'b011001;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        rdy;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic addv(input logic [1:0] o, input logic [5:0] f, input logic r,
                      input logic [19:0] e);
    vec_t v;
    v.op = o; v.funct = f; v.rdy = r; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [19:0] a, input logic [19:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: outputs got 0x%05h required 0x%05h", nm, a, e);
    end
  endtask

  // Called at a falling edge: apply inputs, compare, advance one cycle.
  task automatic cyc(input logic [1:0] o, input logic [5:0] f, input logic r,
                     input logic [19:0] e, input string nm);
    op = o; funct = f; mem_ready = r;
    #1;
    check(nm, act, e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int be_cnt;
    reset_n = 1'b0; op = R; funct = ADD; mem_ready = 1'b0;

    // Reset-state check while reset is held.
    @(negedge clk);
    #1;
    check("reset_state", act, E_IDLE);

    // add
    addv(R, ADD, 1'b1, E_IDLE);
    addv(R, ADD, 1'b1, E_FOK);  addv(R, ADD, 1'b1, E_DEC);
    addv(R, ADD, 1'b0, E_XADD); addv(R, ADD, 1'b1, E_AWB);
    // cmp then lsr
    addv(R, CMP, 1'b1, E_FOK);  addv(R, CMP, 1'b1, E_DEC);  addv(R, CMP, 1'b1, E_XCMP);
    addv(R, LSR, 1'b1, E_FOK);  addv(R, LSR, 1'b1, E_DEC);
    addv(R, LSR, 1'b1, E_XLSR); addv(R, LSR, 1'b1, E_AWB);
    // ldr with three wait cycles in MEM_RD
    addv(M, LDR, 1'b1, E_FOK);  addv(M, LDR, 1'b1, E_DEC);  addv(M, LDR, 1'b0, E_MADR);
    addv(M, LDR, 1'b0, E_MRD);  addv(M, LDR, 1'b0, E_MRD);  addv(M, LDR, 1'b0, E_MRD);
    addv(M, LDR, 1'b1, E_MRD);  addv(M, LDR, 1'b1, E_MWB);
    // str, zero wait
    addv(M, STR, 1'b1, E_FOK);  addv(M, STR, 1'b1, E_DEC);  addv(M, STR, 1'b1, E_MADR);
    addv(M, STR, 1'b1, E_MWR);
    // illegal: op=10, then op=00 funct=111111
    addv(2'b10, ADD, 1'b1, E_FOK); addv(2'b10, ADD, 1'b1, E_ILL);
    addv(R, 6'b111111, 1'b1, E_FOK); addv(R, 6'b111111, 1'b1, E_ILL);
    // sub
    addv(R, SUB, 1'b1, E_FOK);  addv(R, SUB, 1'b1, E_DEC);
    addv(R, SUB, 1'b1, E_XSUB); addv(R, SUB, 1'b1, E_AWB);
    // and with two fetch wait cycles
    addv(R, AND_, 1'b0, E_FW);  addv(R, AND_, 1'b0, E_FW);  addv(R, AND_, 1'b1, E_FOK);
    addv(R, AND_, 1'b1, E_DEC); addv(R, AND_, 1'b1, E_XAND); addv(R, AND_, 1'b1, E_AWB);
    // orr, lsl
    addv(R, ORR, 1'b1, E_FOK);  addv(R, ORR, 1'b1, E_DEC);
    addv(R, ORR, 1'b1, E_XORR); addv(R, ORR, 1'b1, E_AWB);
    addv(R, LSL, 1'b1, E_FOK);  addv(R, LSL, 1'b1, E_DEC);
    addv(R, LSL, 1'b1, E_XLSL); addv(R, LSL, 1'b1, E_AWB);
    // illegal op=11 and op=01 with a non-memory funct
    addv(2'b11, LDR, 1'b1, E_FOK); addv(2'b11, LDR, 1'b1, E_ILL);
    addv(M, ADD, 1'b1, E_FOK);     addv(M, ADD, 1'b1, E_ILL);
    // str with one wait cycle in MEM_WR
    addv(M, STR, 1'b1, E_FOK);  addv(M, STR, 1'b1, E_DEC);  addv(M, STR, 1'b1, E_MADR);
    addv(M, STR, 1'b0, E_MWR);  addv(M, STR, 1'b1, E_MWR);  addv(R, ADD, 1'b1, E_FOK);

    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++)
      cyc(vecs[i].op, vecs[i].funct, vecs[i].rdy, vecs[i].exp, $sformatf("vec%0d", i));

    // Fetch timeout: bus_error only on the 16th wait cycle, then FETCH again.
    do_reset();
    cyc(R, ADD, 1'b0, E_IDLE, "to_idle");
    be_cnt = 0;
    for (int i = 1; i <= 17; i++) begin
      op = R; funct = ADD; mem_ready = 1'b0;
      #1;
      if (bus_error) be_cnt++;
      check($sformatf("fetch_wait%0d", i), act, (i == 16) ? E_FTO : E_FW);
      @(posedge clk);
      @(negedge clk);
    end
    n_chk++;
    if (be_cnt != 1) begin
      n_fail++;
      $display("FAIL fetch_timeout_pulses: got %0d required 1", be_cnt);
    end
    // Counter restarted: 15 more waits, then ready on the 16th wins.
    for (int i = 2; i <= 15; i++)
      cyc(M, LDR, 1'b0, E_FW, $sformatf("refetch_wait%0d", i));
    cyc(M, LDR, 1'b1, E_FOK, "ready_on_limit");
    cyc(M, LDR, 1'b1, E_DEC, "ldr_dec");
    cyc(M, LDR, 1'b1, E_MADR, "ldr_adr");
    for (int i = 1; i <= 15; i++)
      cyc(M, LDR, 1'b0, E_MRD, $sformatf("rd_wait%0d", i));
    cyc(M, LDR, 1'b0, E_MRDTO, "rd_timeout");
    cyc(M, LDR, 1'b0, E_FW, "after_rd_timeout");
    cyc(M, LDR, 1'b1, E_FOK, "after_rd_fetch");

    // Asynchronous reset in MEM_WR.
    do_reset();
    cyc(M, STR, 1'b1, E_IDLE, "rst_idle");
    cyc(M, STR, 1'b1, E_FOK,  "rst_fetch");
    cyc(M, STR, 1'b1, E_DEC,  "rst_dec");
    cyc(M, STR, 1'b0, E_MADR, "rst_madr");
    cyc(M, STR, 1'b0, E_MWR,  "rst_mwr");
    mem_ready = 1'b0;
    #1;
    check("mwr_before_reset", act, E_MWR);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset_drop", act, E_IDLE);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("held_in_reset", act, E_IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(R, ADD, 1'b1, E_IDLE, "restart_idle");
    cyc(2'b11, ADD, 1'b1, E_FOK, "restart_fetch");
    cyc(2'b11, ADD, 1'b1, E_ILL, "restart_illegal");
    cyc(R, ADD, 1'b1, E_FOK, "restart_refetch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
